systolic_edge_feeder: RTL

- Drives the operand edge of a systolic PE column: `ROWS` rows of `VECTOR` lanes, each `REG_WIDTH` wide.
- Takes tile beats from an upstream valid/ready stream and applies the triangular skew the array needs: row r sees beat t exactly r array-advance steps after row 0.
- After the last beat it flushes zeros until every row has seen the full tile, then pulses `done`.
- Sits between the tile buffer and the array's a/b edge inputs; one instance per array edge.

---
 rtl/systolic_edge_feeder_pkg.sv | 19 +
 rtl/systolic_edge_feeder_if.sv | 32 +++
 rtl/systolic_edge_feeder_skew.sv | 29 ++
 rtl/systolic_edge_feeder.sv | 100 ++++++++++
 4 files changed

// File: rtl/systolic_edge_feeder_pkg.sv
// Shared types and defaults for the systolic edge feeder.
// Imported by the feeder top and its bench.
package systolic_pkg;

  localparam int DEF_REG_WIDTH = 16;
  localparam int DEF_VECTOR    = 2;
  localparam int DEF_ROWS      = 4;
  localparam int DEF_KW        = 8;

  typedef logic [DEF_REG_WIDTH-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/systolic_edge_feeder_if.sv
// Beat stream, control and array-edge bundle of the feeder.
// master = tile buffer / controller side, slave = feeder.
interface systolic_edge_feeder_if #(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR    = 2,
  parameter int ROWS      = 4,
  parameter int KW        = 8
);
  localparam int DW = ROWS * VECTOR * REG_WIDTH;

  logic          start;
  logic [KW-1:0] k_len;
  logic          adv;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          underrun;

  modport master (
    output start, k_len, adv, in_valid, in_data,
    input  in_ready, out_data, busy, done, underrun
  );

  modport slave (
    input  start, k_len, adv, in_valid, in_data,
    output in_ready, out_data, busy, done, underrun
  );

endinterface

// File: rtl/systolic_edge_feeder_skew.sv
// adv-enabled register chain with synchronous clear.
// One instance per array row; DEPTH sets that row's skew.
module skew_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        stage[i] <= '0;
    end else if (adv) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_edge_feeder.sv
// Skews tile beats onto a systolic array edge:
// row r lags row 0 by r advance steps, then flushes zeros.
module systolic_edge_feeder
  import systolic_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int VECTOR    = DEF_VECTOR,
  parameter int ROWS      = DEF_ROWS,
  parameter int KW        = DEF_KW
) (
  input logic clk,
  input logic rst_n,
  systolic_edge_feeder_if.slave bus
);

  localparam int RW = VECTOR * REG_WIDTH;
  localparam int DW = ROWS * RW;
  localparam int FW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [FW-1:0] FLAST =
    FW'((ROWS > 1) ? ROWS - 2 : 0);

  feeder_state_t state, nxt;
  logic [KW-1:0] klen_q;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic          und_q;
  logic          feed;
  logic          accept;
  logic          last_beat;
  logic [DW-1:0] push;
  logic [DW-1:0] out_w;

  assign feed      = (state == FEED);
  assign accept    = feed && bus.adv && bus.in_valid;
  assign last_beat = (beat_cnt == klen_q - KW'(1));
  // Only live beats enter; bubbles and all other states shift in zeros.
  assign push      = (feed && bus.in_valid) ? bus.in_data : '0;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start)
          nxt = (bus.k_len == '0) ? DONE : FEED;
      end
      FEED: begin
        if (accept && last_beat)
          nxt = (ROWS == 1) ? DONE : FLUSH;
      end
      FLUSH: begin
        if (bus.adv && flush_cnt == FLAST)
          nxt = DONE;
      end
      DONE: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      klen_q    <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      und_q     <= 1'b0;
    end else begin
      state <= nxt;
      und_q <= feed && bus.adv && !bus.in_valid;
      if (state == IDLE && bus.start) begin
        klen_q   <= bus.k_len;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + KW'(1);
      end
      if (feed)
        flush_cnt <= '0;
      else if (state == FLUSH && bus.adv)
        flush_cnt <= flush_cnt + FW'(1);
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay_line #(
      .WIDTH (RW),
      .DEPTH (r + 1)
    ) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (bus.adv),
      .d     (push[r*RW +: RW]),
      .q     (out_w[r*RW +: RW])
    );
  end

  assign bus.out_data = out_w;
  assign bus.in_ready = feed && bus.adv;
  assign bus.busy     = (state == FEED) || (state == FLUSH);
  assign bus.done     = (state == DONE);
  assign bus.underrun = und_q;

endmodule
